fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin, packet-aware write arbiter that shares one fifo push port among NREQ producers.
//  It tracks FIFO occupancy itself from pushes and pops, so it never uses the FIFO's combinational full output.
//  Each pushed word is tagged with the source requester ID in its upper bits.
//  Sits between the producers and a fifo instance of width WIDTH+IDW and depth DEPTH.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  WIDTH  8  payload width per requester
//  DEPTH  4  depth of the attached fifo; must match the fifo instance exactly
//  IDW    2  requester-ID tag width, = clog2(NREQ)
//  CNTW   3  occupancy counter width, = clog2(DEPTH)+1
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous active-high reset
//  req_valid  in   NREQ         per-requester data valid
//  req_last   in   NREQ         per-requester last word of packet; qualified by valid
//  req_data   in   NREQ*WIDTH   payloads; requester i occupies [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ         word accepted this cycle (combinational)
//  fifo_pop   in   1            pop strobe issued to the fifo by its consumer
//  fifo_push  out  1            push to fifo (combinational)
//  fifo_din   out  WIDTH+IDW    {grant_id, payload} to fifo
//  count      out  CNTW         registered occupancy
//  locked     out  1            registered; a packet owner holds the port
//  owner      out  IDW          registered; current or last granted requester
//  err_uflow  out  1            sticky; a pop was seen while count==0
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, owner=0, count=0, err_uflow=0.
//  - Combinational outputs with all valid low: req_ready=0, fifo_push=0, fifo_din=0.
//  - The fifo must be reset in the same cycle as this block.
//  Space: space = (count < DEPTH), evaluated on the registered count only.
//  - A pop in the same cycle does not free space until the next cycle.
//  IDLE:
//  - If space and any valid, grant g = first valid requester scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//  - On grant: req_ready[g]=1, fifo_push=1, fifo_din={g, req_data[g]}.
//  - If req_last[g]=1: stay IDLE and set rr_ptr<=(g+1)%NREQ.
//  - Else: go LOCKED with owner<=g.
//  - owner<=g on every grant in either case.
//  LOCKED:
//  - Only owner is eligible; req_ready[owner]=valid[owner]&space; all other req_ready=0.
//  - On a push with req_last=1: go IDLE and set rr_ptr<=(owner+1)%NREQ.
//  - Valid low mid-packet: hold LOCKED indefinitely; there is no timeout.
//  Handshake:
//  - A word transfers when valid&ready in the same cycle.
//  - The producer must hold data, last and valid stable until accepted.
//  Occupancy update, with push and pop taken from the same cycle:
//  - push&!pop: count+1.
//  - pop&!push: count-1.
//  - both: unchanged.
//  - pop at count==0: count stays 0 and err_uflow<=1.
//  - count never exceeds DEPTH, because push is impossible when !space.
//  Output timing: at most one push per cycle; acceptance has zero latency.
//  - Data is visible at fifo dataout one cycle after push, when the fifo was empty.
//  Reset mid-packet: the lock is dropped, rr_ptr=0, and the partial packet remains the producer's concern.
//  Arithmetic: the rr_ptr and owner increments wrap modulo NREQ. NREQ need not be a power of two.
// TESTING
//  1 Reset, then all valid=4'b1111 with last=1 and no pops.
//    -> grants 0,1,2,3 on consecutive cycles; count 1..4.
//    -> cycle 5: ready=0 because count==DEPTH.
//  2 Count=4, then one pop.
//    -> next cycle count=3 and requester 0 is granted (rr_ptr wrapped to 0).
//    -> a pop and push in the same cycle leave count unchanged.
//  3 Req1 sends a 3-word packet (last on word 3) while req2 is valid.
//    -> req2.ready=0 throughout.
//    -> after word 3: IDLE, rr_ptr=2, req2 granted the next cycle.
//  4 Req1 is LOCKED and deasserts valid for 5 cycles while req0 and req3 are valid.
//    -> no pushes occur and locked stays 1.
//  5 Rst asserted while LOCKED with count=2.
//    -> next cycle: locked=0, count=0, rr_ptr=0, no push.
//  6 Pop pulse at count=0.
//    -> count stays 0; err_uflow=1 and holds until rst.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for fifo_wr_arbiter: per-requester valid/last/data
// with ready back, plus the shared FIFO push port and the consumer's pop strobe.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic [WIDTH+IDW-1:0]  fifo_din;

    modport master (
        output req_valid, req_last, req_data, fifo_pop,
        input  req_ready, fifo_push, fifo_din
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_pop,
        output req_ready, fifo_push, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin write arbiter sharing one FIFO push port among NREQ producers;
// tracks FIFO occupancy locally from pushes and pops and tags each word with its requester ID.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus,
    output logic [CNTW-1:0]   count,
    output logic              locked,
    output logic [IDW-1:0]    owner,
    output logic              err_uflow
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic              space;
    logic              scan_hit;
    logic [IDW-1:0]    scan_id;
    logic              grant_vld;
    logic              grant_last;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    grant_inc;
    logic [WIDTH-1:0]  data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    // Space is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign space = (count < CNTW'(DEPTH));

    // First valid requester starting at rr_ptr, wrapping modulo NREQ (NREQ need not be 2**IDW).
    always_comb begin : rr_scan
        int             idx;
        logic [IDW-1:0] cand;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        scan_hit = 1'b0;
        scan_id  = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx -= NREQ;
            cand = IDW'(idx);
            if (!scan_hit && bus.req_valid[cand]) begin
                scan_hit = 1'b1;
                scan_id  = cand;
            end
        end
    end

    always_comb begin : grant_sel
        if (state == LOCKED) begin
            grant_id  = owner;
            grant_vld = bus.req_valid[owner] & space;
        end else begin
            grant_id  = scan_id;
            grant_vld = scan_hit & space;
        end
        grant_last = bus.req_last[grant_id];
    end

    assign grant_inc = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;

    // FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin : fsm_next
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld && !grant_last) state_nxt = LOCKED;
            LOCKED:  if (grant_vld &&  grant_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin : fsm_out
        bus.req_ready = '0;
        bus.fifo_push = grant_vld;
        bus.fifo_din  = '0;
        if (grant_vld) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.fifo_din            = {grant_id, data_arr[grant_id]};
        end
    end

    assign locked = (state == LOCKED);

    // Round-robin pointer, owner, occupancy and underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            count     <= '0;
            err_uflow <= 1'b0;
        end else begin
            if (grant_vld) begin
                owner <= grant_id;
                if (grant_last) rr_ptr <= grant_inc;
            end
            if (grant_vld && !bus.fifo_pop)
                count <= count + 1'b1;
            else if (!grant_vld && bus.fifo_pop && count != '0)
                count <= count - 1'b1;
            if (bus.fifo_pop && count == '0)
                err_uflow <= 1'b1;
        end
    end
endmodule
